// File: rtl/axi_burst_master_stream.sv
// rtl/axi_burst_master_stream.sv - AXI4 burst master with streaming write/read beats and per-command status
// Optional 4 KB boundary check: define AXI_BURST_4K_CHECK_EN.
module axi_burst_master_stream #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int WRITE_EN = 1,
  parameter int READ_EN = 1,
  parameter logic [1:0] BURST_TYPE = 2'b01
) (
  input  logic                aclk,
  input  logic                aresetn,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_w_r,
  input  logic [7:0]          cmd_len,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                resp_valid,
  output logic [1:0]          resp,
  output logic                busy
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WRESP, S_RDATA, S_ERR} state_t;
  state_t state, state_n;

  logic              w_r_q, err_seen_q, over_q, resp_valid_q;
  logic [7:0]        len_q, cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        err_code_q, err_resp_q, resp_q;
  logic              cmd_hs, dir_dis, fixed_bad, cross_4k, w_hs, r_hs;
  logic [1:0]        rd_final;

  assign cmd_ready = (state == S_IDLE) && aresetn;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign dir_dis   = cmd_w_r ? (READ_EN == 0) : (WRITE_EN == 0);
  assign fixed_bad = (BURST_TYPE == 2'b00) && (cmd_len > 8'd15);
`ifdef AXI_BURST_4K_CHECK_EN
  logic [23:0] end_byte;
  assign end_byte = 24'(cmd_addr[11:0]) + (24'(cmd_len) + 24'd1) * 24'(STRB_W);
  assign cross_4k = (BURST_TYPE == 2'b01) && (end_byte > 24'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  assign w_hs = (state == S_WDATA) && wr_valid && m_axi_wready;
  assign r_hs = (state == S_RDATA) && m_axi_rvalid && rd_ready;

  // First non-OKAY rresp wins; otherwise a beat-count mismatch reports SLVERR.
  assign rd_final = err_seen_q ? err_resp_q :
                    (m_axi_rresp != 2'b00) ? m_axi_rresp :
                    (over_q || (cnt_q != len_q)) ? 2'b10 : 2'b00;

  assign m_axi_awsize  = SIZE;
  assign m_axi_arsize  = SIZE;
  assign m_axi_awburst = BURST_TYPE;
  assign m_axi_arburst = BURST_TYPE;
  assign resp_valid    = resp_valid_q;
  assign resp          = resp_q;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n       = state;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_rready  = 1'b0;
    wr_ready      = 1'b0;
    rd_data       = '0;
    rd_last       = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      S_IDLE: if (cmd_hs) state_n = (dir_dis || fixed_bad || cross_4k) ? S_ERR : S_ADDR;
      S_ADDR: begin
        if (!w_r_q && (WRITE_EN != 0)) begin
          m_axi_awvalid = 1'b1;
          m_axi_awaddr  = addr_q;
          m_axi_awlen   = len_q;
          if (m_axi_awready) state_n = S_WDATA;
        end else if (w_r_q && (READ_EN != 0)) begin
          m_axi_arvalid = 1'b1;
          m_axi_araddr  = addr_q;
          m_axi_arlen   = len_q;
          if (m_axi_arready) state_n = S_RDATA;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WDATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wdata  = wr_data;
        m_axi_wstrb  = wr_strb;
        m_axi_wlast  = (cnt_q == len_q);
        if (w_hs && (cnt_q == len_q)) state_n = S_WRESP;
      end
      S_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = S_IDLE;
      end
      S_RDATA: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        rd_data      = m_axi_rdata;
        rd_last      = m_axi_rlast;
        if (r_hs && m_axi_rlast) state_n = S_IDLE;
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_r_q        <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      err_seen_q   <= 1'b0;
      err_resp_q   <= '0;
      over_q       <= 1'b0;
      err_code_q   <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt_q      <= '0;
          err_seen_q <= 1'b0;
          over_q     <= 1'b0;
          if (cmd_hs) begin
            w_r_q      <= cmd_w_r;
            len_q      <= cmd_len;
            addr_q     <= cmd_addr;
            err_code_q <= dir_dis ? 2'b11 : 2'b10;
          end
        end
        S_WDATA: if (w_hs) cnt_q <= cnt_q + 8'd1;
        S_WRESP: if (m_axi_bvalid) begin
          resp_q       <= m_axi_bresp;
          resp_valid_q <= 1'b1;
        end
        S_RDATA: if (r_hs) begin
          cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (!err_seen_q && (m_axi_rresp != 2'b00)) begin
            err_seen_q <= 1'b1;
            err_resp_q <= m_axi_rresp;
          end
          if (!m_axi_rlast && (cnt_q >= len_q)) over_q <= 1'b1;
          if (m_axi_rlast) begin
            resp_q       <= rd_final;
            resp_valid_q <= 1'b1;
          end
        end
        S_ERR: begin
          resp_q       <= err_code_q;
          resp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_master_stream.sv
// tb/tb_axi_burst_master_stream.sv - directed vector bench for axi_burst_master_stream
module tb_axi_burst_master_stream;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid = 0, cmd_valid2 = 0, cmd_w_r = 0;
  logic [7:0]  cmd_len = 0;
  logic [31:0] cmd_addr = 0;
  logic [63:0] wr_data = 0;
  logic [7:0]  wr_strb = 0;
  logic        wr_valid = 0, rd_ready = 0;
  logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0;
  logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
  logic [63:0] m_axi_rdata = 0;
  logic        m_axi_rlast = 0, m_axi_rvalid = 0;

  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, resp;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [63:0] m_axi_wdata, rd_data;
  logic        cmd_ready, wr_ready, rd_last, rd_valid, resp_valid, busy;

  logic [31:0] d2_awaddr, d2_araddr;
  logic [7:0]  d2_awlen, d2_arlen, d2_wstrb;
  logic [2:0]  d2_awsize, d2_arsize;
  logic [1:0]  d2_awburst, d2_arburst, d2_resp;
  logic        d2_awvalid, d2_wlast, d2_wvalid, d2_bready, d2_arvalid, d2_rready;
  logic [63:0] d2_wdata, d2_rd_data;
  logic        d2_cmd_ready, d2_wr_ready, d2_rd_last, d2_rd_valid, d2_resp_valid, d2_busy;

  axi_burst_master_stream dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .resp_valid(resp_valid), .resp(resp), .busy(busy)
  );

  axi_burst_master_stream #(.READ_EN(0)) dut_nord (
    .aclk(aclk), .aresetn(aresetn),
    .m_axi_awaddr(d2_awaddr), .m_axi_awlen(d2_awlen), .m_axi_awsize(d2_awsize),
    .m_axi_awburst(d2_awburst), .m_axi_awvalid(d2_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(d2_wdata), .m_axi_wstrb(d2_wstrb), .m_axi_wlast(d2_wlast),
    .m_axi_wvalid(d2_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(d2_bready),
    .m_axi_araddr(d2_araddr), .m_axi_arlen(d2_arlen), .m_axi_arsize(d2_arsize),
    .m_axi_arburst(d2_arburst), .m_axi_arvalid(d2_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(d2_rready),
    .cmd_valid(cmd_valid2), .cmd_ready(d2_cmd_ready), .cmd_w_r(cmd_w_r), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(d2_wr_ready),
    .rd_data(d2_rd_data), .rd_last(d2_rd_last), .rd_valid(d2_rd_valid), .rd_ready(rd_ready),
    .resp_valid(d2_resp_valid), .resp(d2_resp), .busy(d2_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        w_r;
    logic [31:0] addr;
    logic [7:0]  len;
    int          last_beat;
    int          err_beat;
    logic [1:0]  err_val;
    int          err2_beat;
    logic [1:0]  bresp;
    bit          gap;
    logic [1:0]  exp_resp;
    int          exp_beats;
    int          exp_addr_hs;
    int          exp_k;
  } vec_t;

  // Zero-wait slave unless gap is set; k counts edges after the command edge.
  task automatic run_vec(input vec_t v, input int idx);
    int k, resp_k, resp_cnt, addr_hs, bad, wb, rb;
    logic [1:0] resp_got;
    bit addr_done, data_done, b_pend;
    k = 0; resp_k = -1; resp_cnt = 0; addr_hs = 0; bad = 0; wb = 0; rb = 0;
    resp_got = 2'b00; addr_done = 0; data_done = 0; b_pend = 0;
    @(negedge aclk);
    cmd_valid = 1; cmd_w_r = v.w_r; cmd_len = v.len; cmd_addr = v.addr;
    #1 check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    @(posedge aclk);
    while (k < 400 && (resp_k < 0 || k < resp_k + 2)) begin
      @(negedge aclk);
      k++;
      cmd_valid = 0;
      m_axi_awready = 1; m_axi_arready = 1;
      wr_valid = v.gap ? (k % 2 == 0) : 1'b1;
      m_axi_wready = v.gap ? (k % 3 != 1) : 1'b1;
      wr_data = {16'hD00D, 16'(idx), 32'(wb)};
      wr_strb = 8'(wb) ^ 8'hA5;
      m_axi_bvalid = b_pend; m_axi_bresp = v.bresp;
      m_axi_rvalid = v.w_r && addr_done && !data_done;
      m_axi_rdata = {16'hBEEF, 16'(idx), 32'(rb)};
      m_axi_rlast = (rb == v.last_beat);
      m_axi_rresp = (rb == v.err_beat) ? v.err_val : ((rb == v.err2_beat) ? 2'b10 : 2'b00);
      rd_ready = v.gap ? !(k == 4 || k == 5) : 1'b1;
      #1;
      if (m_axi_awvalid && m_axi_awready) begin
        addr_hs++; addr_done = 1;
        if (m_axi_awaddr !== v.addr || m_axi_awlen !== v.len || m_axi_awburst !== 2'b01 || m_axi_awsize !== 3'd3) bad++;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        addr_hs++; addr_done = 1;
        if (m_axi_araddr !== v.addr || m_axi_arlen !== v.len || m_axi_arburst !== 2'b01 || m_axi_arsize !== 3'd3) bad++;
      end
      if (!v.w_r && addr_done && !data_done && !(m_axi_awvalid && m_axi_awready)) begin
        if (m_axi_wvalid !== wr_valid || wr_ready !== m_axi_wready) bad++;
        if (m_axi_wvalid && m_axi_wready) begin
          if (m_axi_wdata !== wr_data || m_axi_wstrb !== wr_strb) bad++;
          if (m_axi_wlast !== (wb == v.len)) bad++;
          if (m_axi_wlast) begin data_done = 1; b_pend = 1; end
          wb++;
        end
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      if (v.w_r && addr_done && !data_done && !(m_axi_arvalid && m_axi_arready)) begin
        if (m_axi_rready !== rd_ready || rd_valid !== m_axi_rvalid) bad++;
        if (m_axi_rvalid && m_axi_rready) begin
          if (rd_data !== m_axi_rdata || rd_last !== m_axi_rlast) bad++;
          if (m_axi_rlast) data_done = 1;
          rb++;
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_k < 0) begin
          resp_k = k; resp_got = resp;
          if (busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
      end
    end
    wr_valid = 0; m_axi_rvalid = 0; m_axi_bvalid = 0;
    check($sformatf("v%0d_resp_cnt", idx), resp_cnt, 1);
    check($sformatf("v%0d_resp", idx), resp_got, v.exp_resp);
    check($sformatf("v%0d_beats", idx), v.w_r ? rb : wb, v.exp_beats);
    check($sformatf("v%0d_addr_hs", idx), addr_hs, v.exp_addr_hs);
    check($sformatf("v%0d_protocol", idx), bad, 0);
    check($sformatf("v%0d_resp_cycle", idx), resp_k, v.exp_k);
  endtask

  vec_t vecs[11];

  initial begin
    int ar2, r2cnt, r2k;
    logic [1:0] r2;
    vecs[0] = '{1'b0, 32'h1000, 8'd3, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 4, 1, 7};
    vecs[1] = '{1'b0, 32'h1000, 8'd3, 0, -1, 2'b00, -1, 2'b00, 1'b1, 2'b00, 4, 1, 14};
    vecs[2] = '{1'b0, 32'h2000, 8'd0, 0, -1, 2'b00, -1, 2'b10, 1'b0, 2'b10, 1, 1, 4};
    vecs[3] = '{1'b1, 32'h8000, 8'd7, 7, 2, 2'b10, -1, 2'b00, 1'b1, 2'b10, 8, 1, 12};
    vecs[4] = '{1'b1, 32'h8100, 8'd3, 1, -1, 2'b00, -1, 2'b00, 1'b0, 2'b10, 2, 1, 4};
    vecs[5] = '{1'b1, 32'h8200, 8'd0, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 1, 1, 3};
    vecs[6] = '{1'b1, 32'h8300, 8'd1, 3, -1, 2'b00, -1, 2'b00, 1'b0, 2'b10, 4, 1, 6};
    vecs[7] = '{1'b1, 32'h8400, 8'd3, 3, 1, 2'b11, 2, 2'b00, 1'b0, 2'b11, 4, 1, 6};
`ifdef AXI_BURST_4K_CHECK_EN
    vecs[8] = '{1'b0, 32'h0FF8, 8'd1, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b10, 0, 0, 2};
`else
    vecs[8] = '{1'b0, 32'h0FF8, 8'd1, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 2, 1, 5};
`endif
    vecs[9]  = '{1'b1, 32'h9000, 8'd255, 255, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 256, 1, 258};
    vecs[10] = '{1'b0, 32'h0FF0, 8'd1, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 2, 1, 5};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_ctrl", {cmd_ready, busy, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                         m_axi_arvalid, m_axi_rready, wr_ready, rd_valid, rd_last, resp_valid, resp}, 0);
    check("reset_data", |{m_axi_awaddr, m_axi_araddr, m_axi_awlen, m_axi_arlen, m_axi_wdata, m_axi_wstrb, rd_data}, 0);
    aresetn = 1;
    #1 check("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in the middle of a write burst.
    @(negedge aclk);
    cmd_valid = 1; cmd_w_r = 0; cmd_len = 8'd3; cmd_addr = 32'h3000;
    wr_valid = 1; m_axi_awready = 1; m_axi_wready = 1;
    @(posedge aclk);
    @(negedge aclk); cmd_valid = 0;
    @(negedge aclk);
    @(negedge aclk); aresetn = 0;
    #1 check("mid_reset_busy_before", busy, 1);
    @(posedge aclk);
    @(negedge aclk);
    #1 check("mid_reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                                   wr_ready, rd_valid, resp_valid, busy, cmd_ready}, 0);
    aresetn = 1; wr_valid = 0;
    #1 check("mid_reset_release", {cmd_ready, resp_valid}, 2'b10);
    run_vec('{1'b0, 32'h3000, 8'd1, 0, -1, 2'b00, -1, 2'b00, 1'b0, 2'b00, 2, 1, 5}, 20);

    // Read command into the instance built without a read path.
    ar2 = 0; r2cnt = 0; r2k = -1; r2 = 2'b00;
    @(negedge aclk);
    cmd_valid2 = 1; cmd_w_r = 1; cmd_len = 8'd0; cmd_addr = 32'h40;
    #1 check("nord_cmd_ready", d2_cmd_ready, 1);
    @(posedge aclk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge aclk);
      cmd_valid2 = 0;
      #1;
      if (d2_arvalid) ar2++;
      if (d2_resp_valid) begin r2cnt++; r2k = k; r2 = d2_resp; end
    end
    check("nord_arvalid", ar2, 0);
    check("nord_resp_cnt", r2cnt, 1);
    check("nord_resp_cycle", r2k, 2);
    check("nord_resp", r2, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
